// File: rtl/hyperram_pkg.sv
// hyperram_pkg: shared types for the HyperRAM request front-end.
// Holds the 48-bit command/address layout, the queued request entry,
// the sequencer state encoding and the CA packing helper.
package hyperram_pkg;

   localparam int unsigned HR_ADDR_W  = 23;
   localparam int unsigned HR_LEN_W   = 11;
   localparam int unsigned HR_CA_W    = 48;
   localparam int unsigned HR_MAX_LEN = 1280;

   // Command/address word as seen by the driver, MSB first
   typedef struct packed {
      logic        rw;
      logic        space;
      logic        linear;
      logic [8:0]  rsvd_hi;
      logic [19:0] addr_hi;
      logic [12:0] rsvd_lo;
      logic [2:0]  addr_lo;
   } ca_t;

   // One queued client request
   typedef struct packed {
      logic                 rw;
      logic                 linear;
      logic [HR_ADDR_W-1:0] addr;
      logic [HR_LEN_W-1:0]  len;
   } req_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_LOAD,
      ST_SETUP,
      ST_XFER,
      ST_DONE
   } state_t;

   // Memory-space access; word address split into row/upper and column bits
   function automatic ca_t pack_ca(input req_t r);
      ca_t ca;
      ca         = '0;
      ca.rw      = r.rw;
      ca.space   = 1'b0;
      ca.linear  = r.linear;
      ca.addr_hi = r.addr[22:3];
      ca.addr_lo = r.addr[2:0];
      return ca;
   endfunction

endpackage

// File: rtl/hyperram_request_arbiter_if.sv
// hyperram_request_arbiter_if: client request bus plus HyperRAM driver handshake.
//   slave  : arbiter side (takes requests and driver status, drives the rest)
//   master : client/driver side
// Signals: reqValid/reqReady/reqAddr/reqLen/reqRw/reqLinear, queueLevel,
// drvEnable/drvCa/drvLen/drvRw/drvSetupDone/drvProcessDone, grantChannel,
// busy, doneValid/doneChannel/doneError, errLen.
interface hyperram_request_arbiter_if
   import hyperram_pkg::*;
#(
   parameter int unsigned CHANNELS    = 4,
   parameter int unsigned QUEUE_DEPTH = 8,
   parameter int unsigned ADDR_W      = HR_ADDR_W,
   parameter int unsigned LEN_W       = HR_LEN_W
);
   localparam int unsigned LVL_W = $clog2(QUEUE_DEPTH) + 1;
   localparam int unsigned CH_W  = $clog2(CHANNELS);

   logic [CHANNELS-1:0]        reqValid;
   logic [CHANNELS-1:0]        reqReady;
   logic [CHANNELS*ADDR_W-1:0] reqAddr;
   logic [CHANNELS*LEN_W-1:0]  reqLen;
   logic [CHANNELS-1:0]        reqRw;
   logic [CHANNELS-1:0]        reqLinear;
   logic [CHANNELS*LVL_W-1:0]  queueLevel;
   logic                       drvEnable;
   logic [HR_CA_W-1:0]         drvCa;
   logic [LEN_W-1:0]           drvLen;
   logic                       drvRw;
   logic                       drvSetupDone;
   logic                       drvProcessDone;
   logic [CH_W-1:0]            grantChannel;
   logic                       busy;
   logic                       doneValid;
   logic [CH_W-1:0]            doneChannel;
   logic                       doneError;
   logic [CHANNELS-1:0]        errLen;

   modport slave (
      input  reqValid, reqAddr, reqLen, reqRw, reqLinear, drvSetupDone, drvProcessDone,
      output reqReady, queueLevel, drvEnable, drvCa, drvLen, drvRw, grantChannel, busy,
             doneValid, doneChannel, doneError, errLen
   );

   modport master (
      output reqValid, reqAddr, reqLen, reqRw, reqLinear, drvSetupDone, drvProcessDone,
      input  reqReady, queueLevel, drvEnable, drvCa, drvLen, drvRw, grantChannel, busy,
             doneValid, doneChannel, doneError, errLen
   );

endinterface

// File: rtl/hyperram_req_queue.sv
// hyperram_req_queue: single-clock FIFO of req_t for one client channel.
//   clk_i/rst_i : clock, synchronous active-high flush
//   push_i/data_i : write an entry (ignored when full)
//   pop_i/data_o  : drop the head entry (ignored when empty); data_o is the head
//   level_o, full_o, empty_o : registered occupancy and its flags
module hyperram_req_queue
   import hyperram_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  req_t                   data_i,
   input  logic                   pop_i,
   output req_t                   data_o,
   output logic [$clog2(DEPTH):0] level_o,
   output logic                   full_o,
   output logic                   empty_o
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   req_t             mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, rd_q;
   logic [LVL_W-1:0] level_q, level_d;
   logic             push_ok, pop_ok;

   assign full_o  = (level_q == LVL_W'(DEPTH));
   assign empty_o = (level_q == '0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_q];
   assign level_o = level_q;

   // Push and pop together leave the level unchanged
   always_comb begin
      level_d = level_q;
      if (push_ok && !pop_ok) begin
         level_d = level_q + LVL_W'(1);
      end else if (!push_ok && pop_ok) begin
         level_d = level_q - LVL_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + PTR_W'(1);
         if (pop_ok)  rd_q <= rd_q + PTR_W'(1);
         level_q <= level_d;
      end
   end

   // Storage needs no flush: pointers and level define validity
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/hyperram_request_arbiter.sv
// hyperram_request_arbiter: multi-client request front-end for the HyperRAM driver.
//   clock200 : sole clock
//   reset    : synchronous active-high reset (flushes queues, forces idle)
//   bus      : request queues, driver handshake and completion/error reporting
// Per-channel queues are served round-robin; the chosen request is packed
// into the CA word and sequenced through the driver with a timeout guard.
module hyperram_request_arbiter
   import hyperram_pkg::*;
#(
   parameter int unsigned CHANNELS       = 4,
   parameter int unsigned QUEUE_DEPTH    = 8,
   parameter int unsigned ADDR_W         = HR_ADDR_W,
   parameter int unsigned LEN_W          = HR_LEN_W,
   parameter int unsigned MAX_LEN        = HR_MAX_LEN,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input logic                       clock200,
   input logic                       reset,
   hyperram_request_arbiter_if.slave bus
);
   localparam int unsigned LVL_W = $clog2(QUEUE_DEPTH) + 1;
   localparam int unsigned CH_W  = $clog2(CHANNELS);
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

   logic [CHANNELS-1:0] push, pop, empty, full, err_len_d;
   logic [LVL_W-1:0]    level [CHANNELS];
   req_t                head  [CHANNELS];

   // Per-channel acceptance, length check and queue
   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [LEN_W-1:0] len;
      logic             accept, legal;
      req_t             entry;

      assign len    = bus.reqLen[c*LEN_W +: LEN_W];
      assign accept = bus.reqValid[c] & ~full[c];
      assign legal  = (len != '0) && (32'(len) <= MAX_LEN);
      assign entry  = '{rw:     bus.reqRw[c],
                        linear: bus.reqLinear[c],
                        addr:   HR_ADDR_W'(bus.reqAddr[c*ADDR_W +: ADDR_W]),
                        len:    HR_LEN_W'(len)};
      // Illegal lengths are consumed (accepted) but never queued
      assign push[c]      = accept & legal;
      assign err_len_d[c] = accept & ~legal;

      hyperram_req_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
         .clk_i   (clock200),
         .rst_i   (reset),
         .push_i  (push[c]),
         .data_i  (entry),
         .pop_i   (pop[c]),
         .data_o  (head[c]),
         .level_o (level[c]),
         .full_o  (full[c]),
         .empty_o (empty[c])
      );

      assign bus.reqReady[c]                    = ~full[c];
      assign bus.queueLevel[c*LVL_W +: LVL_W]   = level[c];
   end

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CH_W-1:0]  last_q, grant_q, win_c, idx_c;
   logic             found_c, timeout_c;
   req_t             cur_q;
   ca_t              drv_ca_q;
   logic [LEN_W-1:0] drv_len_q;
   logic             drv_rw_q, drv_en_q, busy_q, done_valid_q, done_err_q;
   logic [CH_W-1:0]  done_ch_q;
   logic [CHANNELS-1:0] err_len_q;

   // Round-robin search: first non-empty queue starting after the last grant
   always_comb begin
      win_c   = last_q;
      found_c = 1'b0;
      idx_c   = '0;
      for (int unsigned i = 1; i <= CHANNELS; i++) begin
         idx_c = CH_W'((32'(last_q) + i) % CHANNELS);
         if (!found_c && !empty[idx_c]) begin
            win_c   = idx_c;
            found_c = 1'b1;
         end
      end
   end

   // Sequencer next state; completion takes precedence over timeout
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      timeout_c = 1'b0;
      pop       = '0;
      unique case (state_q)
         ST_IDLE: if (found_c) state_d = ST_ARB;
         ST_ARB: begin
            if (found_c) begin
               pop[win_c] = 1'b1;
               state_d    = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            cnt_d   = '0;
            state_d = ST_SETUP;
         end
         ST_SETUP, ST_XFER: begin
            if (bus.drvProcessDone) begin
               state_d = ST_DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d   = ST_DONE;
               timeout_c = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (state_q == ST_SETUP && bus.drvSetupDone) state_d = ST_XFER;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State, bookkeeping and registered outputs (decoded from next state)
   always_ff @(posedge clock200) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         last_q       <= CH_W'(CHANNELS - 1);
         grant_q      <= '0;
         cur_q        <= '0;
         drv_ca_q     <= '0;
         drv_len_q    <= '0;
         drv_rw_q     <= 1'b0;
         drv_en_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_valid_q <= 1'b0;
         done_err_q   <= 1'b0;
         done_ch_q    <= '0;
         err_len_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         drv_en_q     <= (state_d == ST_SETUP) || (state_d == ST_XFER);
         busy_q       <= (state_d != ST_IDLE);
         done_valid_q <= (state_d == ST_DONE);
         done_err_q   <= timeout_c;
         err_len_q    <= err_len_d;
         if (state_q == ST_ARB && found_c) begin
            last_q  <= win_c;
            grant_q <= win_c;
            cur_q   <= head[win_c];
         end
         if (state_q == ST_LOAD) begin
            drv_ca_q  <= pack_ca(cur_q);
            drv_len_q <= LEN_W'(cur_q.len);
            drv_rw_q  <= cur_q.rw;
         end
         if (state_d == ST_DONE) done_ch_q <= grant_q;
      end
   end

   assign bus.drvEnable    = drv_en_q;
   assign bus.drvCa        = drv_ca_q;
   assign bus.drvLen       = drv_len_q;
   assign bus.drvRw        = drv_rw_q;
   assign bus.grantChannel = grant_q;
   assign bus.busy         = busy_q;
   assign bus.doneValid    = done_valid_q;
   assign bus.doneChannel  = done_ch_q;
   assign bus.doneError    = done_err_q;
   assign bus.errLen       = err_len_q;

endmodule

// File: tb/tb_hyperram_request_arbiter.sv
// tb_hyperram_request_arbiter: self-checking bench with a queue-based
// reference model of acceptance, length filtering and round-robin service.
module tb_hyperram_request_arbiter;
   import hyperram_pkg::*;

   localparam int unsigned CH  = 4;
   localparam int unsigned QD  = 8;
   localparam int unsigned AW  = 23;
   localparam int unsigned LW  = 11;
   localparam int unsigned LVW = 4;
   localparam int unsigned TO  = 16;

   typedef struct packed {
      logic          rw;
      logic          lin;
      logic [AW-1:0] addr;
      logic [LW-1:0] len;
   } mreq_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hyperram_request_arbiter_if #(.CHANNELS(CH), .QUEUE_DEPTH(QD), .ADDR_W(AW), .LEN_W(LW)) bus ();

   hyperram_request_arbiter #(
      .CHANNELS(CH), .QUEUE_DEPTH(QD), .ADDR_W(AW), .LEN_W(LW),
      .MAX_LEN(1280), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clock200 (clk),
      .reset    (rst),
      .bus      (bus)
   );

   int    n_pass  = 0;
   int    n_total = 0;
   mreq_t mq [CH][$];
   mreq_t pend [CH];
   int    m_last = CH - 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int model_pick();
      for (int k = 1; k <= CH; k++) begin
         int c;
         c = (m_last + k) % CH;
         if (mq[c].size() > 0) return c;
      end
      return -1;
   endfunction

   function automatic logic [47:0] exp_ca(input mreq_t e);
      logic [47:0] v;
      v = 48'(e.rw) << 47;
      v = v | (48'(e.lin) << 45);
      v = v | (48'(e.addr / 8) << 16);
      v = v | 48'(e.addr % 8);
      return v;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < CH; c++) mq[c].delete();
      m_last = CH - 1;
   endtask

   task automatic drive(input int c, input logic rw, input logic lin,
                        input logic [AW-1:0] addr, input logic [LW-1:0] len);
      bus.reqValid[c]          = 1'b1;
      bus.reqRw[c]             = rw;
      bus.reqLinear[c]         = lin;
      bus.reqAddr[c*AW +: AW]  = addr;
      bus.reqLen[c*LW +: LW]   = len;
      pend[c]                  = '{rw, lin, addr, len};
   endtask

   task automatic drive_rand(input int c, input bit allow_bad);
      logic [LW-1:0] len;
      if (allow_bad && $urandom_range(0, 7) == 0)
         len = ($urandom_range(0, 1) == 0) ? LW'(0) : LW'($urandom_range(1281, 2047));
      else
         len = LW'($urandom_range(1, 1280));
      drive(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom), len);
   endtask

   // One clock edge with the driven requests; model decides acceptance
   task automatic commit_push();
      logic [CH-1:0] exp_err;
      exp_err = '0;
      for (int c = 0; c < CH; c++) begin
         if (bus.reqValid[c]) begin
            check($sformatf("reqReady[%0d]", c), 64'(bus.reqReady[c]), 64'(mq[c].size() < QD));
            if (mq[c].size() < QD) begin
               if (pend[c].len != 0 && pend[c].len <= 1280) mq[c].push_back(pend[c]);
               else exp_err[c] = 1'b1;
            end
         end
      end
      tick();
      bus.reqValid = '0;
      check("errLen", 64'(bus.errLen), 64'(exp_err));
      for (int c = 0; c < CH; c++)
         check($sformatf("queueLevel[%0d]", c), 64'(bus.queueLevel[c*LVW +: LVW]), 64'(mq[c].size()));
   endtask

   // Wait for drvEnable, then compare the presented request with the model's pick
   task automatic expect_grant(output int ch, output bit ok);
      int    w;
      int    pc;
      mreq_t e;
      w  = 0;
      ok = 1'b0;
      ch = -1;
      while (bus.drvEnable !== 1'b1 && w < 12) begin
         tick();
         w++;
      end
      check("grant_wait", 64'(bus.drvEnable), 64'd1);
      if (bus.drvEnable !== 1'b1) return;
      pc = model_pick();
      if (pc < 0) begin
         check("grant_unexpected", 64'(bus.drvEnable), 64'd0);
         return;
      end
      e      = mq[pc].pop_front();
      m_last = pc;
      ch     = pc;
      check("grantChannel", 64'(bus.grantChannel), 64'(pc));
      check("drvLen", 64'(bus.drvLen), 64'(e.len));
      check("drvRw", 64'(bus.drvRw), 64'(e.rw));
      check("drvCa", 64'(bus.drvCa), 64'(exp_ca(e)));
      ok = 1'b1;
   endtask

   task automatic respond(input int ch, input bit early, input int d1, input int d2);
      repeat (d1) tick();
      if (!early) begin
         bus.drvSetupDone = 1'b1;
         tick();
         bus.drvSetupDone = 1'b0;
         repeat (d2) tick();
      end
      bus.drvProcessDone = 1'b1;
      tick();
      bus.drvProcessDone = 1'b0;
      check("doneValid", 64'(bus.doneValid), 64'd1);
      check("doneChannel", 64'(bus.doneChannel), 64'(ch));
      check("doneError", 64'(bus.doneError), 64'd0);
      check("drvEnable_off", 64'(bus.drvEnable), 64'd0);
      tick();
      check("doneValid_pulse", 64'(bus.doneValid), 64'd0);
   endtask

   task automatic serve_one();
      int ch;
      bit ok;
      expect_grant(ch, ok);
      if (ok) respond(ch, $urandom_range(0, 3) == 0, $urandom_range(0, 2), $urandom_range(0, 2));
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size()) > 0 && guard < 40) begin
         serve_one();
         guard++;
      end
   endtask

   initial begin
      int ch;
      bit ok;
      bus.reqValid       = '0;
      bus.reqAddr        = '0;
      bus.reqLen         = '0;
      bus.reqRw          = '0;
      bus.reqLinear      = '0;
      bus.drvSetupDone   = 1'b0;
      bus.drvProcessDone = 1'b0;

      // Reset values
      do_reset();
      check("rst_drvEnable", 64'(bus.drvEnable), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_doneValid", 64'(bus.doneValid), 64'd0);
      check("rst_doneError", 64'(bus.doneError), 64'd0);
      check("rst_errLen", 64'(bus.errLen), 64'd0);
      check("rst_grant", 64'(bus.grantChannel), 64'd0);
      check("rst_doneChannel", 64'(bus.doneChannel), 64'd0);
      check("rst_drvCa", 64'(bus.drvCa), 64'd0);
      check("rst_drvLen", 64'(bus.drvLen), 64'd0);
      check("rst_drvRw", 64'(bus.drvRw), 64'd0);
      check("rst_queueLevel", 64'(bus.queueLevel), 64'd0);
      check("rst_reqReady", 64'(bus.reqReady), 64'hF);

      // Single read on ch0 with latency and CA field checks
      drive(0, 1'b1, 1'b1, 23'h12345B, 11'd64);
      commit_push();
      tick();
      check("lat_t1_enable", 64'(bus.drvEnable), 64'd0);
      check("lat_t1_busy", 64'(bus.busy), 64'd1);
      tick();
      check("lat_t2_enable", 64'(bus.drvEnable), 64'd0);
      tick();
      check("lat_t3_enable", 64'(bus.drvEnable), 64'd1);
      expect_grant(ch, ok);
      check("ca_rw", 64'(bus.drvCa[47]), 64'd1);
      check("ca_space", 64'(bus.drvCa[46]), 64'd0);
      check("ca_linear", 64'(bus.drvCa[45]), 64'd1);
      check("ca_addr_hi", 64'(bus.drvCa[35:16]), 64'h2468B);
      check("ca_addr_lo", 64'(bus.drvCa[2:0]), 64'd3);
      respond(0, 1'b0, 0, 0);

      // Round-robin: two requests per channel, grants 0,1,2,3,0,1,2,3
      do_reset();
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < CH; c++) drive_rand(c, 1'b0);
         commit_push();
      end
      for (int i = 0; i < 8; i++) begin
         expect_grant(ch, ok);
         check($sformatf("rr_order[%0d]", i), 64'(bus.grantChannel), 64'(i % CH));
         if (ok) respond(ch, $urandom_range(0, 3) == 0, $urandom_range(0, 2), $urandom_range(0, 2));
      end

      // Full queue on ch2 while the driver stalls, ending in a timeout
      do_reset();
      drive_rand(0, 1'b0);
      commit_push();
      tick();
      tick();
      tick();
      check("to_enable_rise", 64'(bus.drvEnable), 64'd1);
      expect_grant(ch, ok);
      for (int k = 0; k < 9; k++) begin
         drive_rand(2, 1'b0);
         commit_push();
      end
      check("full_ready", 64'(bus.reqReady[2]), 64'd0);
      check("full_level", 64'(bus.queueLevel[2*LVW +: LVW]), 64'd8);
      for (int n = 10; n < 16; n++) begin
         tick();
         check($sformatf("to_wait[%0d]", n), 64'({bus.doneValid, bus.drvEnable}), 64'b01);
      end
      tick();
      check("to_doneValid", 64'(bus.doneValid), 64'd1);
      check("to_doneError", 64'(bus.doneError), 64'd1);
      check("to_doneChannel", 64'(bus.doneChannel), 64'(ch));
      check("to_drvEnable", 64'(bus.drvEnable), 64'd0);
      tick();
      check("to_done_pulse", 64'(bus.doneValid), 64'd0);
      tick();
      tick();
      check("full_level_after_pop", 64'(bus.queueLevel[2*LVW +: LVW]), 64'd7);
      drain();

      // Illegal lengths on ch1 are dropped with errLen pulses
      drive(1, 1'b0, 1'b0, 23'h000100, 11'd0);
      commit_push();
      drive(1, 1'b1, 1'b1, 23'h000200, 11'd1281);
      commit_push();
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("bad_len_idle[%0d]", k), 64'({bus.busy, bus.drvEnable, bus.errLen}), 64'd0);
      end

      // Reset in the middle of a transfer with requests still queued
      drive_rand(0, 1'b0);
      drive_rand(1, 1'b0);
      drive_rand(3, 1'b0);
      commit_push();
      expect_grant(ch, ok);
      bus.drvSetupDone = 1'b1;
      tick();
      bus.drvSetupDone = 1'b0;
      check("mid_xfer_enable", 64'(bus.drvEnable), 64'd1);
      do_reset();
      check("rstx_drvEnable", 64'(bus.drvEnable), 64'd0);
      check("rstx_levels", 64'(bus.queueLevel), 64'd0);
      check("rstx_busy", 64'(bus.busy), 64'd0);
      check("rstx_doneValid", 64'(bus.doneValid), 64'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("rstx_quiet[%0d]", k), 64'({bus.doneValid, bus.busy}), 64'd0);
      end

      // Randomized rounds: one or two push cycles from idle, then drain
      for (int r = 0; r < 25; r++) begin
         int cycles;
         cycles = $urandom_range(1, 2);
         for (int y = 0; y < cycles; y++) begin
            for (int c = 0; c < CH; c++)
               if ($urandom_range(0, 1) == 1) drive_rand(c, 1'b1);
            commit_push();
         end
         drain();
         repeat (2) tick();
         check($sformatf("rand_idle[%0d]", r), 64'(bus.busy), 64'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
